alu_pipe: RTL and testbench

//   Parametrised, registered successor to the combinational ALU. Width is configurable.

---
 rtl/alu_pipe_if.sv | 32 +++
 rtl/alu_pipe.sv | 191 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the operand-issue logic, the pipelined ALU
// and the writeback stage. The master drives operands and consumes results.
interface alu_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_control;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             carry_flag;
   logic             neg_flag;
   logic             zero_flag;
   logic             overflow_flag;
   logic [3:0]       sticky_flags;
   logic             sticky_clr;

   modport master (
      output in_valid, a, b, alu_control, out_ready, sticky_clr,
      input  in_ready, out_valid, y, carry_flag, neg_flag, zero_flag,
             overflow_flag, sticky_flags
   );

   modport slave (
      input  in_valid, a, b, alu_control, out_ready, sticky_clr,
      output in_ready, out_valid, y, carry_flag, neg_flag, zero_flag,
             overflow_flag, sticky_flags
   );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and a single output register.
// Opcodes 0-12 are single-cycle; opcode 13 is an iterative shift-add multiply
// that always takes WIDTH iterations. Sticky flags OR-accumulate the flags of
// every output transfer.
module alu_pipe #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_pipe_if.slave bus
);
   localparam int M  = WIDTH - 1;
   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;

   typedef enum logic [3:0] {
      OP_OR  = 4'd0,  OP_AND = 4'd1,  OP_NAND = 4'd2,  OP_NOR = 4'd3,
      OP_NOT = 4'd4,  OP_XOR = 4'd5,  OP_ADD  = 4'd6,  OP_SUB = 4'd7,
      OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_CMP  = 4'd10, OP_ROL = 4'd11,
      OP_ROR = 4'd12, OP_MUL = 4'd13
   } op_t;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] acc_q, a_sh_q;
   logic [WIDTH-1:0] b_sh_q;

   logic             out_valid_q;
   logic [WIDTH-1:0] y_q;
   logic [3:0]       flags_q;     // {C,N,Z,V}
   logic [3:0]       sticky_q;

   logic             in_ready, in_fire, out_fire, out_free;
   logic             is_mul, start_mul, load_alu, load_mul;

   logic [WIDTH-1:0]   res_y;
   logic [3:0]         res_f;
   logic [WIDTH:0]     add_full, sub_full;
   logic [2*WIDTH-1:0] rot_tmp;
   logic [3:0]         mul_f;

   // Handshake qualifiers; nothing is accepted while reset is asserted.
   always_comb begin
      out_free  = !out_valid_q || bus.out_ready;
      in_ready  = rst_n && (state_q == S_IDLE) && out_free;
      in_fire   = bus.in_valid && in_ready;
      out_fire  = out_valid_q && bus.out_ready;
      is_mul    = MUL_EN && (bus.alu_control == OP_MUL);
      start_mul = in_fire && is_mul;
      load_alu  = in_fire && !is_mul;
      load_mul  = (state_q == S_HOLD) && out_free;
   end

   // Single-cycle result and flags for opcodes other than an enabled multiply.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      res_y    = '0;
      res_f    = 4'b0000;
      rot_tmp  = '0;
      add_full = {1'b0, bus.a} + {1'b0, bus.b};
      sub_full = {1'b0, bus.a} - {1'b0, bus.b};
      case (bus.alu_control)
         OP_OR:   res_y = bus.a | bus.b;
         OP_AND:  res_y = bus.a & bus.b;
         OP_NAND: res_y = ~(bus.a & bus.b);
         OP_NOR:  res_y = ~(bus.a | bus.b);
         OP_NOT:  res_y = ~bus.a;
         OP_XOR:  res_y = bus.a ^ bus.b;
         OP_ADD: begin
            res_y    = add_full[M:0];
            res_f[3] = add_full[WIDTH];
            res_f[0] = (bus.a[M] == bus.b[M]) && (res_y[M] != bus.a[M]);
         end
         OP_SUB: begin
            res_y    = sub_full[M:0];
            res_f[3] = !sub_full[WIDTH];   // no borrow means a >= b
            res_f[0] = (bus.a[M] ^ bus.b[M]) && (bus.a[M] ^ res_y[M]);
         end
         // Shift amount is the full unsigned b; any bit at or above SW means b >= WIDTH.
         OP_SHL:  res_y = ((bus.b >> SW) != '0) ? '0 : (bus.a << bus.b[SW-1:0]);
         OP_SHR:  res_y = ((bus.b >> SW) != '0) ? '0 : (bus.a >> bus.b[SW-1:0]);
         OP_CMP: begin
            res_y    = {{M{1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            res_f[1] = (bus.a == bus.b);
         end
         OP_ROL: begin
            rot_tmp = {bus.a, bus.a} << bus.b[SW-1:0];
            res_y   = rot_tmp[2*WIDTH-1:WIDTH];
         end
         OP_ROR: begin
            rot_tmp = {bus.a, bus.a} >> bus.b[SW-1:0];
            res_y   = rot_tmp[M:0];
         end
         default: res_f[1] = 1'b1;         // 14, 15 and a disabled multiply
      endcase
      if (bus.alu_control <= OP_SHR || bus.alu_control == OP_ROL ||
          bus.alu_control == OP_ROR)
         res_f[1] = (res_y == '0);
      if (bus.alu_control >= OP_ADD && bus.alu_control <= OP_SHR)
         res_f[2] = res_y[M];
   end

   // Flags of the finished multiply, taken from the double-width accumulator.
   always_comb begin
      mul_f = {(acc_q[2*WIDTH-1:WIDTH] != '0), acc_q[M], (acc_q[M:0] == '0), 1'b0};
   end

   // FSM next state: IDLE issues, MUL iterates, HOLD waits for a free output register.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_mul) state_d = S_MUL;
         S_MUL:  if (cnt_q == CW'(1)) state_d = S_HOLD;
         S_HOLD: if (out_free) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register and iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (start_mul)
            cnt_q <= CW'(WIDTH);
         else if (state_q == S_MUL)
            cnt_q <= cnt_q - CW'(1);
      end
   end

   // Shift-add multiply datapath; a fixed WIDTH iterations regardless of operands.
   // NOTE: these datapath registers are deliberately not reset; they are always
   // loaded on issue before use, and a reset aborts via the FSM and counter.
   always_ff @(posedge clk) begin
      if (start_mul) begin
         a_sh_q <= {{WIDTH{1'b0}}, bus.a};
         b_sh_q <= bus.b;
         acc_q  <= '0;
      end else if (state_q == S_MUL) begin
         if (b_sh_q[0]) acc_q <= acc_q + a_sh_q;
         a_sh_q <= a_sh_q << 1;
         b_sh_q <= b_sh_q >> 1;
      end
   end

   // Output register: loads a new result or drops valid after a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         flags_q     <= 4'b0000;
      end else if (load_alu) begin
         out_valid_q <= 1'b1;
         y_q         <= res_y;
         flags_q     <= res_f;
      end else if (load_mul) begin
         out_valid_q <= 1'b1;
         y_q         <= acc_q[M:0];
         flags_q     <= mul_f;
      end else if (out_fire) begin
         out_valid_q <= 1'b0;
      end
   end

   // Sticky accumulator; a clear wins over a same-cycle accumulate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sticky_q <= 4'b0000;
      else if (bus.sticky_clr)
         sticky_q <= 4'b0000;
      else if (out_fire)
         sticky_q <= sticky_q | flags_q;
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.y             = y_q;
   assign bus.carry_flag    = flags_q[3];
   assign bus.neg_flag      = flags_q[2];
   assign bus.zero_flag     = flags_q[1];
   assign bus.overflow_flag = flags_q[0];
   assign bus.sticky_flags  = sticky_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32, MUL_EN=1): constant vector table
// driven through a scoreboard queue, plus sequences for latency, back-pressure,
// streaming, sticky clear and reset during a multiply.
module tb_alu_pipe;
   typedef struct {
      logic [31:0] y;
      logic [3:0]  f;   // {C,N,Z,V}
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   issue_cyc = 0;
   exp_t sb[$];
   logic [3:0] sticky_exp = 4'b0000;
   vec_t vecs[$];

   alu_pipe_if #(.WIDTH(32)) bus ();

   alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] y, input logic [3:0] f);
      exp_t e;
      e.y = y;
      e.f = f;
      return e;
   endfunction

   function automatic vec_t v(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] y,
                              input logic [3:0] f);
      vec_t r;
      r.op = op; r.a = a; r.b = b; r.e = mk(y, f);
      return r;
   endfunction

   // Drive one operation, wait (bounded) for acceptance, record its expected result.
   task automatic issue(input logic [3:0] op, input logic [31:0] ta,
                        input logic [31:0] tb_v, input exp_t e);
      int waited = 0;
      bus.in_valid    = 1'b1;
      bus.alu_control = op;
      bus.a           = ta;
      bus.b           = tb_v;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: op %0d not accepted in 200 cycles", op);
         bus.in_valid = 1'b0;
         return;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      issue_cyc    = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      while (sb.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Output monitor: pops the scoreboard on every output transfer and tracks sticky flags.
   always @(negedge clk) begin
      exp_t e;
      logic fire;
      fire = 1'b0;
      e = mk('0, 4'b0000);
      if (!rst_n) begin
         sticky_exp = 4'b0000;
      end else begin
         check("sticky", 64'(bus.sticky_flags), 64'(sticky_exp));
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got y=%h with empty scoreboard", bus.y);
            end else begin
               e = sb.pop_front();
               fire = 1'b1;
               check("y", 64'(bus.y), 64'(e.y));
               check("flags", 64'({bus.carry_flag, bus.neg_flag, bus.zero_flag,
                                   bus.overflow_flag}), 64'(e.f));
            end
         end
         if (bus.sticky_clr) sticky_exp = 4'b0000;
         else if (fire) sticky_exp = sticky_exp | e.f;
      end
   end

   initial begin
      int start_c;
      int waited;
      logic ir_seen;

      vecs.push_back(v(4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010));
      vecs.push_back(v(4'd7,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1001));
      vecs.push_back(v(4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000));
      vecs.push_back(v(4'd0,  32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0000));
      vecs.push_back(v(4'd8,  32'h00000001, 32'd40,       32'h00000000, 4'b0010));
      vecs.push_back(v(4'd11, 32'h80000001, 32'd33,       32'h00000003, 4'b0000));
      vecs.push_back(v(4'd1,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 4'b0000));
      vecs.push_back(v(4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0010));
      vecs.push_back(v(4'd3,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0000));
      vecs.push_back(v(4'd4,  32'h12345678, 32'h00000000, 32'hEDCBA987, 4'b0000));
      vecs.push_back(v(4'd5,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000));
      vecs.push_back(v(4'd6,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101));
      vecs.push_back(v(4'd6,  32'h80000000, 32'h80000000, 32'h00000000, 4'b1011));
      vecs.push_back(v(4'd7,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0100));
      vecs.push_back(v(4'd7,  32'h00000005, 32'h00000005, 32'h00000000, 4'b1010));
      vecs.push_back(v(4'd9,  32'h80000000, 32'd31,       32'h00000001, 4'b0000));
      vecs.push_back(v(4'd9,  32'h80000000, 32'd32,       32'h00000000, 4'b0010));
      vecs.push_back(v(4'd8,  32'h00000003, 32'd4,        32'h00000030, 4'b0000));
      vecs.push_back(v(4'd12, 32'h00000001, 32'd1,        32'h80000000, 4'b0000));
      vecs.push_back(v(4'd11, 32'h12345678, 32'd0,        32'h12345678, 4'b0000));
      vecs.push_back(v(4'd10, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0010));
      vecs.push_back(v(4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0000));
      vecs.push_back(v(4'd14, 32'h0000FFFF, 32'h00000003, 32'h00000000, 4'b0010));
      vecs.push_back(v(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0010));
      vecs.push_back(v(4'd13, 32'h00000006, 32'h00000007, 32'h0000002A, 4'b0000));
      vecs.push_back(v(4'd13, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b1100));
      vecs.push_back(v(4'd13, 32'h00000000, 32'h00000005, 32'h00000000, 4'b0010));

      bus.in_valid    = 1'b0;
      bus.a           = '0;
      bus.b           = '0;
      bus.alu_control = 4'd0;
      bus.out_ready   = 1'b1;
      bus.sticky_clr  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_y", 64'(bus.y), 64'd0);
      check("rst_flags", 64'({bus.carry_flag, bus.neg_flag, bus.zero_flag,
                              bus.overflow_flag}), 64'd0);
      check("rst_sticky", 64'(bus.sticky_flags), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD wrap: result valid one cycle after issue
      issue(4'd6, 32'hFFFFFFFF, 32'h1, mk(32'h0, 4'b1010));
      @(negedge clk);
      check("add_latency1", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;

      // Vector table, back to back
      for (int i = 0; i < vecs.size(); i++)
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
      drain();

      // Multiply latency and in_ready low throughout
      @(posedge clk);
      #1;
      issue(4'd13, 32'h00010000, 32'h00010000, mk(32'h0, 4'b1010));
      ir_seen = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!bus.out_valid && waited < 100) begin
         if (bus.in_ready) ir_seen = 1'b1;
         @(negedge clk);
         waited++;
      end
      check("mul_latency", 64'(cyc - issue_cyc), 64'd33);
      check("mul_in_ready_low", 64'(ir_seen), 64'd0);
      drain();

      // Back-pressure: result held stable, in_ready low, single transfer on release
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      issue(4'd0, 32'hF0, 32'h0F, mk(32'hFF, 4'b0000));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_y", 64'(bus.y), 64'hFF);
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("hold_one_transfer", 64'(bus.out_valid), 64'd0);
      check("hold_sb_empty", 64'(sb.size()), 64'd0);

      // Sticky clear wins over a same-cycle accumulate
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      issue(4'd6, 32'hFFFFFFFF, 32'h1, mk(32'h0, 4'b1010));
      @(posedge clk);
      #1;
      bus.out_ready  = 1'b1;
      bus.sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.sticky_clr = 1'b0;
      check("sticky_clr_wins", 64'(bus.sticky_flags), 64'd0);

      // Stream of 8 ops, one accepted per cycle
      @(posedge clk);
      #1;
      start_c = cyc;
      issue(4'd8,  32'h00000001, 32'd40,       mk(32'h00000000, 4'b0010));
      issue(4'd11, 32'h80000001, 32'd33,       mk(32'h00000003, 4'b0000));
      issue(4'd6,  32'd2,        32'd3,        mk(32'h00000005, 4'b0000));
      issue(4'd7,  32'h00000001, 32'h00000002, mk(32'hFFFFFFFF, 4'b0100));
      issue(4'd5,  32'hAAAA5555, 32'hFFFF0000, mk(32'h55555555, 4'b0000));
      issue(4'd1,  32'hFF00FF00, 32'h0F0F0F0F, mk(32'h0F000F00, 4'b0000));
      issue(4'd12, 32'h00000001, 32'd1,        mk(32'h80000000, 4'b0000));
      issue(4'd6,  32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 4'b0101));
      check("stream_8_cycles", 64'(cyc - start_c), 64'd8);
      drain();
      check("sticky_after_stream", 64'(bus.sticky_flags), 64'b0111);
      bus.sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.sticky_clr = 1'b0;
      check("sticky_pulse_clr", 64'(bus.sticky_flags), 64'd0);

      // Reset during a multiply aborts it; a fresh ADD follows with latency 1
      issue(4'd13, 32'd3, 32'd4, mk(32'd12, 4'b0000));
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midmul_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midmul_rst_in_ready", 64'(bus.in_ready), 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(4'd6, 32'd2, 32'd3, mk(32'd5, 4'b0000));
      @(negedge clk);
      check("post_rst_valid", 64'(bus.out_valid), 64'd1);
      check("post_rst_y", 64'(bus.y), 64'd5);
      drain();
      repeat (40) @(negedge clk);
      check("no_stray_output", 64'(bus.out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
